// File: rtl/mac_fifo_pkg.sv
// Shared types and sizing for the MAC array feed path (loader and MAC sequencer).
package mac_fifo_pkg;

    localparam int unsigned ROWS      = 8;
    localparam int unsigned ROW_BYTES = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitData,
        StWrite,
        StNext,
        StDone
    } loader_state_t;

endpackage

// File: rtl/row_unpacker.sv
// Captures one memory row and walks its bytes, MSB byte first, one byte per advance.
module row_unpacker #(
    parameter int unsigned ROW_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [8*ROW_BYTES-1:0] data_in,
    input  logic                   advance,
    output logic [7:0]             byte_out,
    output logic                   last
);

    import mac_fifo_pkg::*;

    localparam int unsigned DATA_W = 8 * ROW_BYTES;
    localparam int unsigned COL_W  = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;

    logic [DATA_W-1:0] row_q;
    logic [COL_W-1:0]  col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load) begin
            row_q <= data_in;
            col_q <= '0;
        end else if (advance) begin
            col_q <= last ? '0 : col_q + 1'b1;
        end
    end

    assign last = (col_q == COL_W'(ROW_BYTES - 1));

    always_comb begin
        byte_out = '0;
        for (int i = 0; i < ROW_BYTES; i++) begin
            if (col_q == COL_W'(i)) byte_out = row_q[DATA_W-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/mem_fifo_loader.sv
// Fetches 1+ROWS memory rows and scatters their bytes into the B FIFO and the A FIFOs.
// Optional MEM_FIFO_LOADER_CHECKSUM_EN adds a 16-bit running sum of all written bytes.
module mem_fifo_loader #(
    parameter int unsigned ROWS      = mac_fifo_pkg::ROWS,
    parameter int unsigned ROW_BYTES = mac_fifo_pkg::ROW_BYTES,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [ADDR_W-1:0]      mem_address,
    output logic                   mem_read,
    input  logic [8*ROW_BYTES-1:0] mem_readdata,
    input  logic                   mem_readdatavalid,
    input  logic                   mem_waitrequest,
    output logic [7:0]             fifo_data,
    output logic                   wren_b,
    output logic [ROWS-1:0]        wren_a,
    input  logic                   full_b,
    input  logic [ROWS-1:0]        full_a,
    output logic                   busy,
`ifdef MEM_FIFO_LOADER_CHECKSUM_EN
    output logic [15:0]            checksum,
`endif
    output logic                   done
);

    import mac_fifo_pkg::*;

    localparam int unsigned ROW_W = $clog2(ROWS + 1);

    loader_state_t  state_q;
    logic [ROW_W-1:0] row_q;
    logic           mem_read_q;
    logic           busy_q;
    logic           done_q;

    logic           load;
    logic           strobe;
    logic           last;
    logic           full_sel;
    logic [7:0]     byte_out;

    assign load = (state_q == StWaitData) && mem_readdatavalid;

    // Row 0 feeds B; row k (k>=1) feeds A[k-1].
    always_comb begin
        full_sel = full_b;
        for (int k = 0; k < ROWS; k++) begin
            if (row_q == ROW_W'(k + 1)) full_sel = full_a[k];
        end
        strobe = (state_q == StWrite) && !full_sel;
        wren_b = strobe && (row_q == '0);
        wren_a = '0;
        for (int k = 0; k < ROWS; k++) begin
            wren_a[k] = strobe && (row_q == ROW_W'(k + 1));
        end
    end

    row_unpacker #(
        .ROW_BYTES (ROW_BYTES)
    ) u_unpacker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data_in  (mem_readdata),
        .advance  (strobe),
        .byte_out (byte_out),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row_q      <= '0;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StReq;
                        row_q      <= '0;
                        mem_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                StReq: begin
                    if (!mem_waitrequest) begin
                        state_q    <= StWaitData;
                        mem_read_q <= 1'b0;
                    end
                end
                StWaitData: begin
                    if (mem_readdatavalid) state_q <= StWrite;
                end
                StWrite: begin
                    if (strobe && last) state_q <= StNext;
                end
                StNext: begin
                    if (row_q == ROW_W'(ROWS)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= StReq;
                        row_q      <= row_q + 1'b1;
                        mem_read_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_address = ADDR_W'(row_q);
    assign mem_read    = mem_read_q;
    assign fifo_data   = byte_out;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef MEM_FIFO_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if ((state_q == StIdle || state_q == StDone) && start) begin
            checksum_q <= '0;
        end else if (strobe) begin
            checksum_q <= checksum_q + {8'h00, byte_out};
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Self-checking bench for mem_fifo_loader: memory responder, FIFO-full stimulus and a
// queue-based model of the byte stream every load must produce.
module tb_mem_fifo_loader;

    import mac_fifo_pkg::*;

    localparam int DW = 8 * ROW_BYTES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic [31:0]   mem_address;
    logic          mem_read;
    logic [DW-1:0] mem_readdata = '0;
    logic          mem_readdatavalid = 1'b0;
    logic          mem_waitrequest = 1'b0;
    logic [7:0]    fifo_data;
    logic          wren_b;
    logic [ROWS-1:0] wren_a;
    logic          full_b = 1'b0;
    logic [ROWS-1:0] full_a = '0;
    logic          busy;
    logic          done;
`ifdef MEM_FIFO_LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    mem_fifo_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest),
        .fifo_data         (fifo_data),
        .wren_b            (wren_b),
        .wren_a            (wren_a),
        .full_b            (full_b),
        .full_a            (full_a),
        .busy              (busy),
`ifdef MEM_FIFO_LOADER_CHECKSUM_EN
        .checksum          (checksum),
`endif
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] b;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          data_mode = 0;
    int          wait_hold = 0;
    int          hold_seen = 0;
    bit          stall_en = 0;
    bit          spur_en = 0;
    bit          go = 0;
    bit          rdv_real = 0;
    int          lat = 0;
    int          pend_row = 0;
    int          wcnt = 0;
    int          wrow = -1;
    int          accepts = 0;
    int          exp_addr = 0;
    int          strobes = 0;
    logic [15:0] sum_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int r, input int c, input int mode);
        if (mode == 0) return 8'(r);
        return 8'(r * 16 + c);
    endfunction

    function automatic logic [DW-1:0] mem_word(input int r, input int mode);
        logic [DW-1:0] w;
        w = '0;
        for (int c = 0; c < ROW_BYTES; c++) w[DW-1-8*c -: 8] = exp_byte(r, c, mode);
        return w;
    endfunction

    // Memory side: waitrequest, 2-cycle read latency, stall and spurious-input injection.
    initial begin
        forever begin
            bit real_prev;
            @(negedge clk);
            if (!rst_n) begin
                mem_readdatavalid = 1'b0;
                mem_waitrequest = 1'b0;
                rdv_real = 0;
                lat = 0;
                wcnt = 0;
                full_a = '0;
                start = 1'b0;
                continue;
            end
            real_prev = rdv_real;
            rdv_real = 0;
            mem_readdatavalid = 1'b0;
            start = 1'b0;
            if (real_prev) begin
                wcnt = 1;
                wrow = pend_row;
            end else if (wcnt > 0) begin
                wcnt++;
            end
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = mem_word(pend_row, data_mode);
                    rdv_real = 1;
                end
            end
            mem_waitrequest = 1'b0;
            if (mem_read) begin
                check("rd_addr", mem_address, 32'(exp_addr));
                if (spur_en && !mem_readdatavalid) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = {(DW/32){32'hDEAD_BEEF}};
                end
                if (wait_hold > 0 && mem_address == 32'd3) begin
                    mem_waitrequest = 1'b1;
                    wait_hold--;
                    hold_seen++;
                end else begin
                    pend_row = int'(mem_address);
                    lat = 2;
                    exp_addr++;
                    accepts++;
                    wcnt = 0;
                end
            end
            if (spur_en && wcnt == 2) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = {(DW/32){32'h0BAD_F00D}};
            end
            full_a = '0;
            if (stall_en && wrow == 5 && wcnt >= 3 && wcnt <= 6) full_a[4] = 1'b1;
            if (go) begin
                start = 1'b1;
                go = 0;
            end else if (spur_en && wcnt == 5) begin
                start = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the expected byte stream.
    initial begin
        forever begin
            int nh;
            int t;
            logic fsel;
            exp_t e;
            @(negedge clk);
            #1;
            if (!rst_n) begin
                check("rst_ctrl", 32'({mem_read, wren_b, wren_a, busy, done}), 32'd0);
                check("rst_addr", mem_address, 32'd0);
                check("rst_data", 32'(fifo_data), 32'd0);
                continue;
            end
            nh = $countones({wren_b, wren_a});
            check("strobe_onehot", 32'(nh <= 1), 32'd1);
            check("busy_done_excl", 32'(busy && done), 32'd0);
            if (nh == 1) begin
                t = 0;
                for (int k = 0; k < ROWS; k++) if (wren_a[k]) t = k + 1;
                fsel = (t == 0) ? full_b : full_a[t-1];
                check("strobe_while_full", 32'(fsel), 32'd0);
                check("strobe_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("strobe_target", 32'(t), 32'(e.t));
                    check("strobe_byte", 32'(fifo_data), 32'(e.b));
                    sum_model = sum_model + {8'h00, e.b};
                end
                strobes++;
            end
        end
    end

    task automatic prep_load();
        exp_t e;
        q.delete();
        sum_model = '0;
        strobes = 0;
        accepts = 0;
        exp_addr = 0;
        hold_seen = 0;
        for (int r = 0; r <= ROWS; r++) begin
            for (int c = 0; c < ROW_BYTES; c++) begin
                e.t = r;
                e.b = exp_byte(r, c, data_mode);
                q.push_back(e);
            end
        end
    endtask

    task automatic run_load(input string tag, input int exp_cycles);
        int cyc;
        prep_load();
        go = 1;
        @(negedge clk);
        #2;
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            cyc++;
            if (cyc == 1) check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        end while (!done && cyc < 3000);
        check({tag, "_cycles_to_done"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_strobes"}, 32'(strobes), 32'((ROWS + 1) * ROW_BYTES));
        check({tag, "_leftover"}, 32'(q.size()), 32'd0);
        check({tag, "_reads"}, 32'(accepts), 32'(ROWS + 1));
`ifdef MEM_FIFO_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 32'(checksum), 32'(sum_model));
`endif
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_read", 32'(mem_read), 32'd0);

        // Replicated-byte rows, no stalls: 9 rows x (1 + 2 + 8 + 1) cycles.
        data_mode = 0;
        run_load("basic", 1 + 9 * 12);
        check("basic_sum_literal", 32'(sum_model), 32'h0120);
`ifdef MEM_FIFO_LOADER_CHECKSUM_EN
        check("basic_checksum_literal", 32'(checksum), 32'h0120);
`endif
        repeat (3) @(negedge clk);
        #2;
        check("done_holds", 32'(done), 32'd1);

        // Per-column distinct bytes from here on, so ordering errors are visible.
        data_mode = 1;
        wait_hold = 5;
        run_load("waitreq", 1 + 9 * 12 + 5);
        check("waitreq_hold_cycles", 32'(hold_seen), 32'd5);
        wait_hold = 0;

        stall_en = 1;
        run_load("stall", 1 + 9 * 12 + 4);
        stall_en = 0;

        spur_en = 1;
        run_load("spurious", 1 + 9 * 12);
        spur_en = 0;

        // Reset in the middle of row 2's WRITE, then a fresh load from address 0.
        prep_load();
        go = 1;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(wrow == 2 && wcnt == 3) && n < 500);
        check("rst_point_reached", 32'(wrow == 2 && wcnt == 3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({mem_read, wren_b, wren_a, busy, done}), 32'd0);
        check("midrst_addr", mem_address, 32'd0);
        check("midrst_data", 32'(fifo_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_load("after_reset", 1 + 9 * 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
